// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch-flush squash
// and saturating stall/flush performance counters.
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [DATA_W-1:0]  id_pc_plus4,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic [4:0]         id_rd,
  input  logic               id_uses_rt,
  input  logic [DATA_W-1:0]  id_rdata1,
  input  logic [DATA_W-1:0]  id_rdata2,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic               id_reg_dst,
  input  logic [ALUOP_W-1:0] id_alu_op,
  output logic [DATA_W-1:0]  ex_pc_plus4,
  output logic [4:0]         ex_rs,
  output logic [4:0]         ex_rt,
  output logic [4:0]         ex_rd,
  output logic [DATA_W-1:0]  ex_rdata1,
  output logic [DATA_W-1:0]  ex_rdata2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic               ex_reg_dst,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_valid,
  output logic               stall,
  output logic [CNT_W-1:0]   stall_count,
  output logic [CNT_W-1:0]   flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic hazard;
  logic bubble;

  always_comb begin
    hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 5'd0)
           & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

  // rst gates stall directly so it drops without waiting for a clock edge
  assign stall  = hazard & ~flush & ~rst;
  assign bubble = flush | hazard | ~id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_pc_plus4   <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_rdata1     <= '0;
      ex_rdata2     <= '0;
      ex_imm        <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_op     <= '0;
    end else if (bubble) begin
      ex_valid      <= 1'b0;
      ex_pc_plus4   <= '0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_rdata1     <= '0;
      ex_rdata2     <= '0;
      ex_imm        <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_reg_dst    <= 1'b0;
      ex_alu_op     <= '0;
    end else begin
      ex_valid      <= 1'b1;
      ex_pc_plus4   <= id_pc_plus4;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_rdata1     <= id_rdata1;
      ex_rdata2     <= id_rdata2;
      ex_imm        <= id_imm;
      ex_reg_write  <= id_reg_write;
      ex_mem_read   <= id_mem_read;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_alu_src    <= id_alu_src;
      ex_reg_dst    <= id_reg_dst;
      ex_alu_op     <= id_alu_op;
    end
  end

  // Performance counters hold at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_ONE;
      if (flush && id_valid && (flush_count != '1))
        flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, reset/saturation sequences and
// randomized traffic against a behavioural model of the EX stage.
module tb_id_ex_stage;

  localparam int CW = 10;  // narrow counters keep saturation reachable quickly
  localparam logic [CW-1:0] CMAX = '1;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, id_valid, id_uses_rt;
  logic [31:0] id_pc_plus4, id_rdata1, id_rdata2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [3:0]  id_alu_op;
  logic [31:0] ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [3:0]  ex_alu_op;
  logic        ex_valid, stall;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .ALUOP_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_pc_plus4(id_pc_plus4), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_alu_op(id_alu_op),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
    .ex_alu_op(ex_alu_op), .ex_valid(ex_valid), .stall(stall),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] r1, r2, imm;
    logic        rw, mr, mw, m2r, asrc, rdst;
    logic [3:0]  alu;
  } ex_t;

  ex_t dut_ex;
  assign dut_ex = {ex_valid, ex_pc_plus4, ex_rs, ex_rt, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
                   ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src,
                   ex_reg_dst, ex_alu_op};

  typedef struct {
    logic        flush, valid;
    logic [4:0]  rs, rt;
    logic        uses, mr, rw;
    logic [31:0] r1;
    logic [3:0]  alu;
    logic        e_stall, e_valid;
    logic [31:0] e_r1;
    logic [3:0]  e_alu;
    logic        e_rw, e_mr;
    int          e_scnt, e_fcnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic fl, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic mr, input logic rw,
                        input logic [31:0] r1, input logic [3:0] alu);
    flush = fl; id_valid = v; id_rs = rs; id_rt = rt; id_rd = 5'd3; id_uses_rt = uses;
    id_mem_read = mr; id_reg_write = rw; id_rdata1 = r1; id_alu_op = alu;
    id_pc_plus4 = r1 + 32'd4; id_rdata2 = ~r1; id_imm = {16'h0, r1[15:0]};
    id_mem_write = ~rw; id_mem_to_reg = mr; id_alu_src = mr; id_reg_dst = ~mr;
  endtask

  // Behavioural model of what EX should hold after each edge
  ex_t m;
  int  m_scnt, m_fcnt;

  function automatic logic model_hazard();
    return id_valid && m.valid && m.mr && (m.rt != 5'd0)
           && ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
  endfunction

  task automatic model_edge();
    logic hz;
    hz = model_hazard();
    if (hz && !flush && m_scnt < int'(CMAX)) m_scnt++;
    if (flush && id_valid && m_fcnt < int'(CMAX)) m_fcnt++;
    if (flush || hz || !id_valid) m = '0;
    else m = '{1'b1, id_pc_plus4, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
               id_reg_dst, id_alu_op};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_id(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m = '0; m_scnt = 0; m_fcnt = 0;
  endtask

  vec_t tv[17];

  initial begin
    tv[0]  = '{0,1,1,2,1,0,1,32'h12345678,2, 0,1,32'h12345678,2,1,0, 0,0};
    tv[1]  = '{0,1,1,5,0,1,1,32'hAAAA0001,0, 0,1,32'hAAAA0001,0,1,1, 0,0};
    tv[2]  = '{0,1,5,6,1,0,1,32'hBBBB0002,2, 1,0,32'h0,0,0,0,         1,0};
    tv[3]  = '{0,1,5,6,1,0,1,32'hBBBB0002,2, 0,1,32'hBBBB0002,2,1,0, 1,0};
    tv[4]  = '{0,1,0,7,0,1,1,32'hCCCC0004,0, 0,1,32'hCCCC0004,0,1,1, 1,0};
    tv[5]  = '{0,1,1,7,0,0,1,32'hDDDD0005,3, 0,1,32'hDDDD0005,3,1,0, 1,0};
    tv[6]  = '{0,1,0,7,0,1,1,32'hCCCC0004,0, 0,1,32'hCCCC0004,0,1,1, 1,0};
    tv[7]  = '{0,1,2,7,1,0,0,32'hEEEE0007,0, 1,0,32'h0,0,0,0,         2,0};
    tv[8]  = '{0,1,2,7,1,0,0,32'hEEEE0007,0, 0,1,32'hEEEE0007,0,0,0, 2,0};
    tv[9]  = '{0,1,3,0,0,1,1,32'hFFFF0009,0, 0,1,32'hFFFF0009,0,1,1, 2,0};
    tv[10] = '{0,1,0,0,1,0,1,32'h1111000A,5, 0,1,32'h1111000A,5,1,0, 2,0};
    tv[11] = '{0,1,1,9,0,1,1,32'h2222000B,0, 0,1,32'h2222000B,0,1,1, 2,0};
    tv[12] = '{1,1,9,1,1,0,1,32'h3333000C,2, 0,0,32'h0,0,0,0,         2,1};
    tv[13] = '{0,0,4,4,1,0,1,32'h4444000D,2, 0,0,32'h0,0,0,0,         2,1};
    tv[14] = '{0,1,1,4,0,1,1,32'h5555000E,0, 0,1,32'h5555000E,0,1,1, 2,1};
    tv[15] = '{0,1,4,4,1,0,1,32'h6666000F,2, 1,0,32'h0,0,0,0,         3,1};
    tv[16] = '{0,1,4,4,1,0,1,32'h6666000F,2, 0,1,32'h6666000F,2,1,0, 3,1};

    // Reset state, sampled while rst is still high
    rst = 1'b1;
    set_id(1'b0, 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    check("rst_ex", 256'(dut_ex), 256'(0));
    check("rst_stall", 256'(stall), 256'(0));
    check("rst_cnt", 256'({stall_count, flush_count}), 256'(0));
    do_reset();

    foreach (tv[i]) begin
      set_id(tv[i].flush, tv[i].valid, tv[i].rs, tv[i].rt, tv[i].uses, tv[i].mr, tv[i].rw,
             tv[i].r1, tv[i].alu);
      @(negedge clk);
      check($sformatf("tv%0d_stall", i), 256'(stall), 256'(tv[i].e_stall));
      @(posedge clk); #1;
      check($sformatf("tv%0d_ex", i),
            256'({ex_valid, ex_rdata1, ex_alu_op, ex_reg_write, ex_mem_read}),
            256'({tv[i].e_valid, tv[i].e_r1, tv[i].e_alu, tv[i].e_rw, tv[i].e_mr}));
      check($sformatf("tv%0d_cnt", i), 256'({stall_count, flush_count}),
            256'({CW'(tv[i].e_scnt), CW'(tv[i].e_fcnt)}));
    end

    // Asynchronous reset in the middle of a load-use stall
    set_id(1'b0, 1'b1, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 32'h0000_0111, 4'h0);
    @(posedge clk); #1;
    set_id(1'b0, 1'b1, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 32'h0000_0222, 4'h2);
    @(negedge clk);
    check("mid_stall_pre", 256'(stall), 256'(1));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_stall", 256'(stall), 256'(0));
    check("mid_rst_ex", 256'(dut_ex), 256'(0));
    check("mid_rst_cnt", 256'({stall_count, flush_count}), 256'(0));
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      flush        = ($urandom_range(9, 0) == 0);
      id_valid     = ($urandom_range(7, 0) != 0);
      id_rs        = 5'($urandom_range(7, 0));
      id_rt        = 5'($urandom_range(7, 0));
      id_rd        = 5'($urandom_range(31, 0));
      id_uses_rt   = 1'($urandom);
      id_mem_read  = 1'($urandom);
      id_reg_write = 1'($urandom);
      id_mem_write = 1'($urandom);
      id_mem_to_reg = 1'($urandom);
      id_alu_src   = 1'($urandom);
      id_reg_dst   = 1'($urandom);
      id_alu_op    = 4'($urandom);
      id_pc_plus4  = $urandom;
      id_rdata1    = $urandom;
      id_rdata2    = $urandom;
      id_imm       = $urandom;
      @(negedge clk);
      check("rnd_stall", 256'(stall), 256'(model_hazard() && !flush));
      @(posedge clk);
      model_edge();
      #1;
      check("rnd_ex", 256'(dut_ex), 256'(m));
      check("rnd_cnt", 256'({stall_count, flush_count}), 256'({CW'(m_scnt), CW'(m_fcnt)}));
    end

    // Saturation: a self-dependent load stalls every other cycle
    do_reset();
    set_id(1'b0, 1'b1, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 32'h0000_0333, 4'h0);
    repeat (2 * int'(CMAX) + 20) @(posedge clk);
    #1;
    check("sat_stall", 256'(stall_count), 256'(CMAX));
    check("sat_flush_idle", 256'(flush_count), 256'(0));
    flush = 1'b1;
    repeat (int'(CMAX) + 10) @(posedge clk);
    #1;
    check("sat_flush", 256'(flush_count), 256'(CMAX));
    flush = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("sat_hold", 256'({stall_count, flush_count}), 256'({CMAX, CMAX}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
